// File: rtl/mc10415_bank_ctl.sv
// Round-robin sequencer for a bank of mc10415a 1Kx1 ECL RAMs.
// Two requesters share one bank; strobe timing is set by parameters.
module mc10415_bank_ctl #(
  parameter int WIDTH     = 36,
  parameter int SETUP_CYC = 1,
  parameter int WP_CYC    = 2,
  parameter int RD_CYC    = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [1:0]       req,
  input  logic [1:0]       we,
  input  logic [9:0]       addr0,
  input  logic [9:0]       addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] rdata,
  output logic [9:0]       ram_a,
  output logic [WIDTH-1:0] ram_d,
  output logic             ram_nen,
  output logic             ram_nwrite,
  input  logic [WIDTH-1:0] ram_q
);

  localparam int MAXC =
    (SETUP_CYC > WP_CYC) ?
      ((SETUP_CYC > RD_CYC) ? SETUP_CYC : RD_CYC) :
      ((WP_CYC > RD_CYC) ? WP_CYC : RD_CYC);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTB,
    S_WSET,
    S_WPUL,
    S_WHLD,
    S_ACK
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_ld;
  logic             w_done;
  logic             w_win;
  logic             w_start;
  logic             w_acc;
  logic             r_last;
  logic             r_grant;
  logic [1:0]       r_ack;
  logic [WIDTH-1:0] r_rdata;
  logic [9:0]       r_a;
  logic [WIDTH-1:0] r_d;
  logic             r_nen;
  logic             r_nwrite;

  assign ack        = r_ack;
  assign rdata      = r_rdata;
  assign ram_a      = r_a;
  assign ram_d      = r_d;
  assign ram_nen    = r_nen;
  assign ram_nwrite = r_nwrite;

  // Next state, arbitration winner and counter reload value
  always_comb begin
    w_next  = r_state;
    w_ld    = '0;
    w_done  = (r_cnt == '0);
    w_win   = (req == 2'b11) ? ~r_last : req[1];
    w_start = (r_state == S_IDLE) && (|req);
    unique case (r_state)
      S_IDLE: if (|req) w_next = we[w_win] ? S_WSET : S_RSTB;
      S_RSTB: if (w_done) w_next = S_ACK;
      S_WSET: if (w_done) w_next = S_WPUL;
      S_WPUL: if (w_done) w_next = S_WHLD;
      S_WHLD: w_next = S_ACK;
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    unique case (w_next)
      S_RSTB:  w_ld = CW'(RD_CYC - 1);
      S_WSET:  w_ld = CW'(SETUP_CYC - 1);
      S_WPUL:  w_ld = CW'(WP_CYC - 1);
      default: w_ld = '0;
    endcase
    w_acc = (w_next == S_RSTB) || (w_next == S_WSET) ||
            (w_next == S_WPUL) || (w_next == S_WHLD);
  end

  // State register and per-state cycle counter
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= w_ld;
      else if (!w_done) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Grant, address/data latch and round-robin memory
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_a     <= '0;
      r_d     <= '0;
    end else if (w_start) begin
      r_last  <= w_win;
      r_grant <= w_win;
      r_a     <= w_win ? addr1 : addr0;
      r_d     <= w_win ? wdata1 : wdata0;
    end
  end

  // Registered strobes and ack, decoded from the next state
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_nen    <= 1'b1;
      r_nwrite <= 1'b1;
      r_ack    <= 2'b00;
    end else begin
      r_nen    <= ~w_acc;
      r_nwrite <= (w_next != S_WPUL);
      r_ack    <= (w_next == S_ACK) ? {r_grant, ~r_grant} : 2'b00;
    end
  end

  // Capture q on the final read-strobe cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_rdata <= '0;
    else if (r_state == S_RSTB && w_done) r_rdata <= ram_q;
  end

endmodule

// File: tb/tb_mc10415_bank_ctl.sv
// Bench for mc10415_bank_ctl: bank model, scoreboard monitor,
// strobe-invariant monitor and directed/random stimulus.
module tb_mc10415_bank_ctl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [9:0]  addr0 = '0;
  logic [9:0]  addr1 = '0;
  logic [35:0] wdata0 = '0;
  logic [35:0] wdata1 = '0;
  logic [1:0]  ack;
  logic [35:0] rdata;
  logic [9:0]  ram_a;
  logic [35:0] ram_d;
  logic        ram_nen;
  logic        ram_nwrite;
  logic [35:0] ram_q;

  mc10415_bank_ctl dut (
    .clk(clk), .nreset(nreset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .ram_a(ram_a), .ram_d(ram_d),
    .ram_nen(ram_nen), .ram_nwrite(ram_nwrite), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // bank of 36 mc10415a: write while nen & nwrite low
  logic [35:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk)
    if (!ram_nen && !ram_nwrite) mem[ram_a] <= ram_d;
  assign ram_q = (!ram_nen && ram_nwrite) ? mem[ram_a] : '0;

  typedef struct {
    int          r;
    logic [35:0] d;
  } exp_t;

  exp_t        sbq[$];
  logic [35:0] shadow [1024];
  logic [35:0] last_rd = '0;
  int          tests = 0;
  int          fails = 0;
  int          ack_cnt = 0;

  initial for (int i = 0; i < 1024; i++) shadow[i] = '0;

  // scoreboard and strobe-invariant monitor
  int          wr_run = 0;
  bit          nen_win = 0;
  bit          nen_bad = 0;
  logic [9:0]  a_hold;
  logic [35:0] d_hold;
  always @(negedge clk) begin
    exp_t e;
    if (!nreset) begin
      wr_run  = 0;
      nen_win = 0;
    end else begin
      if (ack == 2'b11) begin
        tests++; fails++;
        $display("FAIL ack_both: ack=%b required one-hot", ack);
      end else if (ack != 2'b00) begin
        ack_cnt++;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL ack_unexpected: ack=%b", ack);
        end else begin
          e = sbq.pop_front();
          if (ack != (e.r == 1 ? 2'b10 : 2'b01) || rdata !== e.d) begin
            fails++;
            $display("FAIL sb: ack=%b rdata=%o required ack[%0d] rdata=%o",
                     ack, rdata, e.r, e.d);
          end
        end
      end
      if (!ram_nwrite && ram_nen) begin
        tests++; fails++;
        $display("FAIL nwrite_nen: nwrite=0 nen=1 required nen=0");
      end
      if (!ram_nwrite) wr_run++;
      else if (wr_run != 0) begin
        tests++;
        if (wr_run != 2) begin
          fails++;
          $display("FAIL wp_width: got %0d cycles required 2", wr_run);
        end
        wr_run = 0;
      end
      if (!ram_nen) begin
        if (!nen_win) begin
          nen_win = 1; nen_bad = 0;
          a_hold = ram_a; d_hold = ram_d;
        end else if (ram_a !== a_hold || ram_d !== d_hold) nen_bad = 1;
      end else if (nen_win) begin
        nen_win = 0;
        tests++;
        if (nen_bad) begin
          fails++;
          $display("FAIL a_d_stable: ram_a/ram_d moved during nen low at a=%h", a_hold);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // one access from an idle bank; call at a negedge
  task automatic access(input int r, input bit w, input logic [9:0] a,
                        input logic [35:0] d);
    exp_t e;
    int   n;
    e.r = r;
    if (w) begin
      e.d = last_rd;
      shadow[a] = d;
    end else begin
      e.d = shadow[a];
      last_rd = shadow[a];
    end
    sbq.push_back(e);
    if (r == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    we[r] = w;
    req[r] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (r == 0) begin addr0 = ~a; wdata0 = ~d; end
      else begin addr1 = ~a; wdata1 = ~d; end
      @(negedge clk);
    end while (!ack[r] && n < 40);
    req[r] = 1'b0;
    chk(w ? "wr_latency" : "rd_latency", 64'(n), w ? 64'd5 : 64'd3);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          n;
    exp_t        e;
    logic [63:0] t;

    repeat (3) @(negedge clk);
    chk("rst_nen", 64'(ram_nen), 64'd1);
    chk("rst_nwrite", 64'(ram_nwrite), 64'd1);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_ram_a", 64'(ram_a), 64'd0);
    chk("rst_ram_d", 64'(ram_d), 64'd0);
    nreset = 1'b1;
    @(negedge clk);

    // T2 write/read
    access(0, 1, 10'h155, 36'o123456701234);
    access(0, 0, 10'h155, '0);
    chk("t2_rdata", 64'(rdata), 64'(36'o123456701234));
    access(1, 1, 10'h0AA, 36'o707070707070);

    // T1 reset mid write pulse
    addr0 = 10'h3C0; wdata0 = 36'o111111111111;
    we[0] = 1'b1; req[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ram_nwrite && n < 20);
    chk("t1_reach_wpul", 64'(ram_nwrite), 64'd0);
    #2 nreset = 1'b0;
    #1;
    chk("t1_nen", 64'(ram_nen), 64'd1);
    chk("t1_nwrite", 64'(ram_nwrite), 64'd1);
    chk("t1_ack", 64'(ack), 64'd0);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    chk("t1_rdata", 64'(rdata), 64'd0);
    last_rd = '0;
    @(negedge clk);

    // T3 tie, both reads held; last_grant=1 after reset
    for (int i = 0; i < 2; i++) begin
      e.r = 0; e.d = shadow[10'h155]; sbq.push_back(e);
      e.r = 1; e.d = shadow[10'h0AA]; sbq.push_back(e);
    end
    addr0 = 10'h155; addr1 = 10'h0AA; we = 2'b00;
    base = ack_cnt;
    req = 2'b11;
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (ack_cnt < base + 4 && n < 200);
    req = 2'b00;
    chk("t3_acks", 64'(ack_cnt - base), 64'd4);
    last_rd = shadow[10'h0AA];
    @(negedge clk);
    @(negedge clk);

    // T4 random accesses
    for (int i = 0; i < 100; i++) begin
      t = {$urandom(), $urandom()};
      access(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             10'h100 + 10'($urandom_range(0, 255)), t[35:0]);
    end

    // T5 address edges
    access(0, 1, 10'h200, 36'o252525252525);
    access(0, 1, 10'h000, 36'o777777777777);
    access(1, 1, 10'h3FF, 36'o0);
    access(1, 0, 10'h000, '0);
    chk("t5_rd000", 64'(rdata), 64'(36'o777777777777));
    access(0, 0, 10'h3FF, '0);
    chk("t5_rd3ff", 64'(rdata), 64'd0);
    access(1, 0, 10'h200, '0);
    chk("t5_rd200", 64'(rdata), 64'(36'o252525252525));

    // T6 requester 1 abandons its write after one cycle
    e.r = 1; e.d = last_rd; sbq.push_back(e);
    shadow[10'h0F0] = 36'o135713571357;
    addr1 = 10'h0F0; wdata1 = 36'o135713571357;
    we[1] = 1'b1;
    base = ack_cnt;
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    addr1 = 10'h0F1; wdata1 = '0;
    repeat (12) @(negedge clk);
    #1;
    chk("t6_ack_once", 64'(ack_cnt - base), 64'd1);
    @(negedge clk);
    access(0, 0, 10'h0F0, '0);
    chk("t6_rdback", 64'(rdata), 64'(36'o135713571357));

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
